// File: rtl/fan_axil_regs.sv
// fan_axil_regs - AXI4-Lite register block and PWM generator for the fan controller.
//
// Registers (word index = addr[4:2]):
//   0x00 CTRL    bit0 = enable
//   0x04 PERIOD  PWM period in clock cycles
//   0x08 DUTY    PWM high time in clock cycles
//   0x0C SCRATCH free read/write word
//   0x10 TACH    read-only tach edge count per 2^26-cycle window (FAN_TACH_EN only)
//
// Optional feature macro: FAN_TACH_EN (tach edge counter at 0x10).
//
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN  clock, asynchronous active-low reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B*  AXI4-Lite write channels (AWPROT ignored)
//   S_AXI_AR* / S_AXI_R*             AXI4-Lite read channels (ARPROT ignored)
//   fan_pwm   registered PWM drive output
//   fan_tach  tach pulse input (only used with FAN_TACH_EN)
module fan_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int PWM_CNT_WIDTH      = 32
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            fan_pwm,
    input  logic                            fan_tach
);

    localparam logic [PWM_CNT_WIDTH-1:0] CNT_ONE  = {{(PWM_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PWM_CNT_WIDTH-1:0] CNT_ZERO = {PWM_CNT_WIDTH{1'b0}};

    // Byte-wise merge of new data into an old word under a strobe mask.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_w[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_w[b*8 +: 8];
            end
        end
        return res;
    endfunction

    logic [31:0] regs_r [4];

    // Write channel state
    logic                          awready_r, wready_r, bvalid_r;
    logic                          aw_latched_r, w_latched_r;
    logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_r;
    logic [31:0]                   wdata_r;
    logic [3:0]                    wstrb_r;

    logic                          aw_hs_s, w_hs_s, b_hs_s, do_write_s;
    logic                          aw_latched_nx_s, w_latched_nx_s, bvalid_nx_s;
    logic [C_S_AXI_ADDR_WIDTH-1:0] waddr_s;
    logic [31:0]                   wdata_s;
    logic [3:0]                    wstrb_s;

    // Read channel state
    logic        arready_r, rvalid_r;
    logic [31:0] rdata_r;
    logic        ar_hs_s, rvalid_nx_s;
    logic [31:0] rd_word_s;
    logic [31:0] tach_rd_s;

    // PWM state
    logic [PWM_CNT_WIDTH-1:0] cnt_r, period_s_r, duty_s_r;
    logic                     pwm_r;
    logic                     enable_s;

    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = wready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RDATA   = rdata_r;
    assign S_AXI_RRESP   = 2'b00;
    assign fan_pwm       = pwm_r;
    assign enable_s      = regs_r[0][0];

    // Write handshake decode; an address or data beat arriving this cycle counts
    // as latched so a same-cycle AW+W completes in one edge.
    always_comb begin
        aw_hs_s    = S_AXI_AWVALID && awready_r;
        w_hs_s     = S_AXI_WVALID && wready_r;
        b_hs_s     = bvalid_r && S_AXI_BREADY;
        waddr_s    = aw_latched_r ? awaddr_r : S_AXI_AWADDR;
        wdata_s    = w_latched_r ? wdata_r : S_AXI_WDATA;
        wstrb_s    = w_latched_r ? wstrb_r : S_AXI_WSTRB;
        do_write_s = (aw_latched_r || aw_hs_s) && (w_latched_r || w_hs_s) && !bvalid_r;
        if (b_hs_s) begin
            aw_latched_nx_s = 1'b0;
            w_latched_nx_s  = 1'b0;
            bvalid_nx_s     = 1'b0;
        end else begin
            aw_latched_nx_s = aw_latched_r || aw_hs_s;
            w_latched_nx_s  = w_latched_r || w_hs_s;
            bvalid_nx_s     = bvalid_r || do_write_s;
        end
    end

    // Write channel registers and register file update.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            awready_r    <= 1'b0;
            wready_r     <= 1'b0;
            bvalid_r     <= 1'b0;
            aw_latched_r <= 1'b0;
            w_latched_r  <= 1'b0;
            awaddr_r     <= {C_S_AXI_ADDR_WIDTH{1'b0}};
            wdata_r      <= 32'd0;
            wstrb_r      <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else begin
            aw_latched_r <= aw_latched_nx_s;
            w_latched_r  <= w_latched_nx_s;
            bvalid_r     <= bvalid_nx_s;
            awready_r    <= !aw_latched_nx_s && !bvalid_nx_s;
            wready_r     <= !w_latched_nx_s && !bvalid_nx_s;
            if (aw_hs_s) begin
                awaddr_r <= S_AXI_AWADDR;
            end
            if (w_hs_s) begin
                wdata_r <= S_AXI_WDATA;
                wstrb_r <= S_AXI_WSTRB;
            end
            // Words 4..7 (including the read-only tach word) drop writes.
            if (do_write_s && !waddr_s[4]) begin
                regs_r[waddr_s[3:2]] <= apply_strb(regs_r[waddr_s[3:2]], wdata_s, wstrb_s);
            end
        end
    end

    // Read data selection by word index.
    always_comb begin
        case (S_AXI_ARADDR[4:2])
            3'd0:    rd_word_s = regs_r[0];
            3'd1:    rd_word_s = regs_r[1];
            3'd2:    rd_word_s = regs_r[2];
            3'd3:    rd_word_s = regs_r[3];
            3'd4:    rd_word_s = tach_rd_s;
            default: rd_word_s = 32'd0;
        endcase
    end

    always_comb begin
        ar_hs_s = S_AXI_ARVALID && arready_r;
        if (ar_hs_s) begin
            rvalid_nx_s = 1'b1;
        end else if (rvalid_r && S_AXI_RREADY) begin
            rvalid_nx_s = 1'b0;
        end else begin
            rvalid_nx_s = rvalid_r;
        end
    end

    // Read channel registers; RDATA samples the pre-write register contents.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'd0;
        end else begin
            rvalid_r  <= rvalid_nx_s;
            arready_r <= !rvalid_nx_s;
            if (ar_hs_s) begin
                rdata_r <= rd_word_s;
            end
        end
    end

    // PWM counter, shadow loading and registered output. A zero period is
    // treated as a wrap every cycle so new settings are still picked up.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            cnt_r      <= CNT_ZERO;
            period_s_r <= CNT_ZERO;
            duty_s_r   <= CNT_ZERO;
            pwm_r      <= 1'b0;
        end else if (!enable_s) begin
            cnt_r      <= CNT_ZERO;
            period_s_r <= regs_r[1][PWM_CNT_WIDTH-1:0];
            duty_s_r   <= regs_r[2][PWM_CNT_WIDTH-1:0];
            pwm_r      <= 1'b0;
        end else if (period_s_r == CNT_ZERO) begin
            cnt_r      <= CNT_ZERO;
            period_s_r <= regs_r[1][PWM_CNT_WIDTH-1:0];
            duty_s_r   <= regs_r[2][PWM_CNT_WIDTH-1:0];
            pwm_r      <= 1'b0;
        end else begin
            pwm_r <= (cnt_r < duty_s_r);
            if (cnt_r == period_s_r - CNT_ONE) begin
                cnt_r      <= CNT_ZERO;
                period_s_r <= regs_r[1][PWM_CNT_WIDTH-1:0];
                duty_s_r   <= regs_r[2][PWM_CNT_WIDTH-1:0];
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

`ifdef FAN_TACH_EN
    logic        tach_s1_r, tach_s2_r, tach_d_r;
    logic [25:0] win_r;
    logic [31:0] edge_cnt_r, tach_reg_r;
    logic        tach_rise_s;

    assign tach_rise_s = tach_s2_r && !tach_d_r;
    assign tach_rd_s   = tach_reg_r;

    // Tach synchroniser, edge counter and window snapshot.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            tach_s1_r  <= 1'b0;
            tach_s2_r  <= 1'b0;
            tach_d_r   <= 1'b0;
            win_r      <= 26'd0;
            edge_cnt_r <= 32'd0;
            tach_reg_r <= 32'd0;
        end else begin
            tach_s1_r <= fan_tach;
            tach_s2_r <= tach_s1_r;
            tach_d_r  <= tach_s2_r;
            win_r     <= win_r + 26'd1;
            if (win_r == 26'h3FF_FFFF) begin
                // An edge on the closing cycle still belongs to this window.
                tach_reg_r <= edge_cnt_r + {31'd0, tach_rise_s};
                edge_cnt_r <= 32'd0;
            end else if (tach_rise_s) begin
                edge_cnt_r <= edge_cnt_r + 32'd1;
            end else begin
                edge_cnt_r <= edge_cnt_r;
            end
        end
    end

    logic unused_s;
    assign unused_s = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], waddr_s[1:0]};
`else
    assign tach_rd_s = 32'd0;

    logic unused_s;
    assign unused_s = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_ARADDR[1:0], waddr_s[1:0],
                        fan_tach};
`endif

endmodule

// File: tb/tb_fan_axil_regs.sv
// Self-checking bench for fan_axil_regs: table-driven write/readback vectors
// plus directed sequences for handshake ordering, back-pressure, PWM shadowing
// and reset mid-transaction.
module tb_fan_axil_regs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  awaddr = 5'd0, araddr = 5'd0;
    logic [2:0]  awprot = 3'd0, arprot = 3'd0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic [3:0]  wstrb = 4'd0;
    logic        awready, wready, bvalid, arready, rvalid, fan_pwm;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        fan_tach = 1'b0;

    int checks = 0;
    int failures = 0;
    int bhs_count = 0;

    always #5 clk = ~clk;

    fan_axil_regs dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .fan_pwm(fan_pwm), .fan_tach(fan_tach)
    );

    // Counts completed write responses.
    always @(posedge clk) begin
        if (bvalid && bready) bhs_count <= bhs_count + 1;
    end

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        bit aw_done, w_done, aw_hs, w_hs;
        int n;
        aw_done = 0; w_done = 0; n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(negedge clk);
            if (aw_hs) begin aw_done = 1; awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  wvalid = 1'b0; end
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (n >= 20) timeout_fail("aw_w_handshake");
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        if (!bvalid) timeout_fail("bvalid_wait");
        else check("bresp", {30'd0, bresp}, 32'd0);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
        int n;
        n = 0;
        araddr = a; arvalid = 1'b1;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        if (!arready) timeout_fail("arready_wait");
        @(negedge clk);
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin @(negedge clk); n++; end
        if (!rvalid) timeout_fail("rvalid_wait");
        else check("rresp", {30'd0, rresp}, 32'd0);
        d = rdata;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic wait_rise(input string name);
        logic prev;
        int n;
        prev = fan_pwm; n = 0;
        @(negedge clk);
        while (!(fan_pwm && !prev) && n < 30) begin prev = fan_pwm; @(negedge clk); n++; end
        if (n >= 30) timeout_fail(name);
    endtask

    task automatic measure_high(output int run);
        run = 0;
        while (fan_pwm && run < 20) begin run++; @(negedge clk); end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, held;
        int          highs, run, b0;

        vecs[0] = '{5'h00, 32'h0000_0001, 4'hF, 32'h0000_0001};
        vecs[1] = '{5'h04, 32'h0000_0002, 4'hF, 32'h0000_0002};
        vecs[2] = '{5'h08, 32'h0000_0003, 4'hF, 32'h0000_0003};
        vecs[3] = '{5'h0C, 32'h0000_0004, 4'hF, 32'h0000_0004};
        vecs[4] = '{5'h0C, 32'hAABB_CCDD, 4'hF, 32'hAABB_CCDD};
        vecs[5] = '{5'h0C, 32'h1122_3344, 4'h5, 32'hAA22_CC44};
        vecs[6] = '{5'h0C, 32'hFFFF_FFFF, 4'h8, 32'hFF22_CC44};
        vecs[7] = '{5'h10, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000};
        vecs[8] = '{5'h1C, 32'h1234_5678, 4'hF, 32'h0000_0000};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_awready", {31'd0, awready}, 32'd0);
        check("rst_wready",  {31'd0, wready},  32'd0);
        check("rst_arready", {31'd0, arready}, 32'd0);
        check("rst_bvalid",  {31'd0, bvalid},  32'd0);
        check("rst_rvalid",  {31'd0, rvalid},  32'd0);
        check("rst_rdata",   rdata,            32'd0);
        check("rst_pwm",     {31'd0, fan_pwm}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_awready", {31'd0, awready}, 32'd1);
        check("post_rst_arready", {31'd0, arready}, 32'd1);

        // Table: write then read back
        for (int i = 0; i < 9; i++) begin
            axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
            axi_read(vecs[i].addr, rd);
            check($sformatf("readback_%0d", i), rd, vecs[i].exp);
        end
        axi_read(5'h00, rd); check("rb_ctrl",   rd, 32'd1);
        axi_read(5'h04, rd); check("rb_period", rd, 32'd2);
        axi_read(5'h08, rd); check("rb_duty",   rd, 32'd3);

        // DUTY 3 >= PERIOD 2: constantly high
        highs = 0;
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (fan_pwm) highs++; end
        check("pwm_duty_ge_period", highs, 32'd10);

        // W three cycles before AW
        b0 = bhs_count;
        wdata = 32'h0000_0055; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        check("w_first_wready_low", {31'd0, wready}, 32'd0);
        check("w_first_awready",    {31'd0, awready}, 32'd1);
        repeat (2) @(negedge clk);
        check("w_first_no_bvalid", {31'd0, bvalid}, 32'd0);
        awaddr = 5'h0C; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        check("w_first_bvalid", {31'd0, bvalid}, 32'd1);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        repeat (3) @(negedge clk);
        check("w_first_one_resp", bhs_count - b0, 32'd1);
        axi_read(5'h0C, rd);
        check("w_first_data", rd, 32'h0000_0055);

        // AW and W in the same cycle
        b0 = bhs_count;
        axi_write(5'h0C, 32'h0000_0066, 4'hF);
        repeat (3) @(negedge clk);
        check("same_cycle_one_resp", bhs_count - b0, 32'd1);
        axi_read(5'h0C, rd);
        check("same_cycle_data", rd, 32'h0000_0066);

        // Simultaneous read and write of SCRATCH: read sees the old value
        awaddr = 5'h0C; wdata = 32'h0000_0099; wstrb = 4'hF; araddr = 5'h0C;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("rw_same_rvalid", {31'd0, rvalid}, 32'd1);
        check("rw_same_old",    rdata,           32'h0000_0066);
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        axi_read(5'h0C, rd);
        check("rw_same_new", rd, 32'h0000_0099);

        // PWM 3 of 10, then DUTY change takes effect at the next wrap
        axi_write(5'h00, 32'd0, 4'hF);
        axi_write(5'h04, 32'd10, 4'hF);
        axi_write(5'h08, 32'd3, 4'hF);
        axi_write(5'h00, 32'd1, 4'hF);
        repeat (5) @(negedge clk);
        highs = 0;
        for (int i = 0; i < 30; i++) begin if (fan_pwm) highs++; @(negedge clk); end
        check("pwm_3_of_10", highs, 32'd9);
        wait_rise("pwm_rise_1");
        fork
            axi_write(5'h08, 32'd7, 4'hF);
            measure_high(run);
        join
        check("pwm_old_duty_kept", run, 32'd3);
        wait_rise("pwm_rise_2");
        measure_high(run);
        check("pwm_new_duty", run, 32'd7);

        // Back-pressure hold, then reset mid-hold
        awaddr = 5'h0C; wdata = 32'h0000_0077; wstrb = 4'hF; araddr = 5'h08;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        held = rdata;
        check("hold_rdata_first", held, 32'd7);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("hold_bvalid_%0d", i),  {31'd0, bvalid},  32'd1);
            check($sformatf("hold_rvalid_%0d", i),  {31'd0, rvalid},  32'd1);
            check($sformatf("hold_rdata_%0d", i),   rdata,            32'd7);
            check($sformatf("hold_awready_%0d", i), {31'd0, awready}, 32'd0);
            check($sformatf("hold_arready_%0d", i), {31'd0, arready}, 32'd0);
        end
        #1 rst_n = 1'b0;
        #1;
        check("midrst_bvalid",  {31'd0, bvalid},  32'd0);
        check("midrst_rvalid",  {31'd0, rvalid},  32'd0);
        check("midrst_rdata",   rdata,            32'd0);
        check("midrst_awready", {31'd0, awready}, 32'd0);
        check("midrst_arready", {31'd0, arready}, 32'd0);
        check("midrst_pwm",     {31'd0, fan_pwm}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_midrst_no_b", {31'd0, bvalid}, 32'd0);
        check("post_midrst_no_r", {31'd0, rvalid}, 32'd0);
        axi_read(5'h08, rd);
        check("post_midrst_duty_clear", rd, 32'd0);
`ifndef FAN_TACH_EN
        axi_read(5'h10, rd);
        check("tach_word_unmapped", rd, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
